pipe_drain_ctrl: RTL
====================

Name: pipe_drain_ctrl

Overview:
- Downstream companion of the unbalanced 64-bit multiply pipe (fixed latency, no stall capability, in_valid/out_valid only).
- Issues credit-based admission grants to the pipe's source so results are never dropped.
- Buffers pipe results in a FIFO.
- Serializes each 64-bit result as two 32-bit beats on a valid/ready master interface.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DW, 64, result width; fixed at 2*OW.
- OW, 32, output beat width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  1  source requests to launch one operand set into the pipe
- src_ready  out  1  launch permitted this cycle; the launch occurs when src_valid && src_ready
- pipe_out_valid  in  1  result strobe from the pipe
- pipe_out  in  DW  result data from the pipe
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  OW  output beat data
- m_last  out  1  high on the second (upper) beat of a result
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky error: a result was dropped

Behaviour:
- Reset (rst_n low, asynchronous) clears all state:
  - FIFO pointers, count, inflight counter, beat flag and overflow go to 0.
  - Outputs while in reset: src_ready=1, m_valid=0, m_data=0, m_last=0, level=0, overflow=0.
  - The pipe shares rst_n, so no in-flight results survive reset.
- Credit logic:
  - launch = src_valid && src_ready.
  - src_ready = (count + inflight) < DEPTH. It is combinational from registers only and never depends on src_valid.
  - inflight_next = inflight + launch - pipe_out_valid. Simultaneous launch and arrival leave inflight unchanged.
- FIFO:
  - Push when pipe_out_valid. pipe_out is written at wr_ptr.
  - Pop when the high beat is accepted.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave count unchanged; this is legal when full.
  - Push while count==DEPTH and no pop in the same cycle: data is dropped, overflow is set and stays 1 until reset. count and pointers are unchanged.
  - Push while empty: the entry is visible on m_valid the next cycle. There is no bypass; minimum pipe-result-to-m_valid latency is 1 cycle.
- Serializer FSM, 2 states keyed on beat:
  - LO (beat=0): m_valid = count!=0, m_data = head[OW-1:0], m_last=0. On m_valid && m_ready, go to HI.
  - HI (beat=1): m_valid=1, m_data = head[DW-1:OW], m_last=1. On m_ready, pop and go to LO.
  - m_valid, m_data and m_last depend only on registers; there is no combinational path from m_ready.
  - Once m_valid is asserted, m_data is held stable until accepted.
  - m_data=0 whenever m_valid=0.
- level = count, registered.
- Throughput: one result per 2 cycles at sustained m_ready=1. Source launches throttle automatically through credit.
- inflight never exceeds DEPTH. Counter width is $clog2(DEPTH+1).

Decomposition:
- Shared package pipe_pkg holds:
  - the DW/OW localparams
  - the typedef result_t (logic [63:0])
  - the beat_e enum {BEAT_LO, BEAT_HI}
- One natural sub-module: drain_fifo (storage, pointers, count, overflow).
- The credit counter and serializer FSM stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-traffic (count=3, inflight=2) -> all outputs return to reset values immediately; after release src_ready=1, level=0.
- Single result: pipe_out=64'h1122_3344_5566_7788 with m_ready=1 -> next cycle beat 32'h5566_7788 (m_last=0), following cycle 32'h1122_3344 (m_last=1), then m_valid=0 and level=0.
- Credit limit: DEPTH=8, m_ready=0, src_valid held 1 -> exactly 8 launches granted, then src_ready=0. The 8 results arrive, level=8, no overflow. Raise m_ready: one result drains every 2 cycles, src_ready reasserts after the first pop.
- Backpressure stability: m_ready toggles 1,0,0,1 during a result -> m_data/m_last are held while m_ready=0; beats are delivered in order with no duplication.
- Full with simultaneous push and pop: count=8, pipe_out_valid coincides with the HI beat accepted -> count stays 8, overflow stays 0, wr_ptr wraps 7->0.
- Forced overflow: with src_ready ignored and count=8, inject pipe_out_valid while m_ready=0 -> data is dropped, overflow=1 sticky, level=8, and the FIFO contents are unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the multiply-pipe drain path.
//   DW       : result width delivered by the multiply pipe
//   OW       : beat width on the downstream valid/ready interface
//   result_t : one full pipe result
//   beat_e   : serializer beat selector (lower half first, then upper half)
package pipe_pkg;

  localparam int DW = 64;
  localparam int OW = 32;

  typedef logic [63:0] result_t;

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_e;

endpackage

// File: rtl/drain_fifo.sv
// Result buffer behind the fixed-latency multiply pipe.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : store push_data this cycle (the pipe cannot stall)
//   push_data   : result written at the write pointer
//   pop         : discard the head entry
//   head        : entry at the read pointer
//   count       : number of stored entries (0..DEPTH)
//   overflow    : sticky flag, set when a push found the buffer full with no pop
module drain_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = pipe_pkg::DW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          full_s;
  logic          do_pop_s;
  logic          do_push_s;
  logic          drop_s;

  // Push/pop qualification; a push into a full buffer is only kept when a pop frees a slot
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && (!full_s || do_pop_s);
    drop_s    = push && full_s && !do_pop_s;
  end

  // Storage array, written at the write pointer; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/pipe_drain_ctrl.sv
// Downstream controller for the non-stallable 64-bit multiply pipe.
// Grants launches only while buffer space is guaranteed for every result in
// flight, buffers results, and serializes each as two beats (low half, then
// high half with m_last) on a valid/ready master interface.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   src_valid/ready : launch handshake toward the pipe source
//   pipe_out_valid  : result strobe from the pipe, pipe_out its data
//   m_valid/ready   : output beat handshake, m_data beat, m_last upper beat
//   level           : buffer occupancy
//   overflow        : sticky, a result was dropped
module pipe_drain_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = pipe_pkg::DW,
  parameter int OW    = pipe_pkg::OW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic                       pipe_out_valid,
  input  logic [DW-1:0]              pipe_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OW-1:0]              m_data,
  output logic                       m_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] inflight_r;
  logic [CW-1:0] inflight_next_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   credit_sum_s;
  logic          launch_s;
  logic          pop_s;
  logic [DW-1:0] head_s;
  logic          overflow_s;
  beat_e         beat_r;
  beat_e         beat_next_s;
  logic          m_valid_s;
  logic [OW-1:0] m_data_s;
  logic          m_last_s;

  drain_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_out_valid),
    .push_data (pipe_out),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .overflow  (overflow_s)
  );

  // Credit check: stored plus in-flight results must leave room for one more launch
  always_comb begin
    credit_sum_s = {1'b0, count_s} + {1'b0, inflight_r};
    src_ready    = (credit_sum_s < (CW + 1)'(DEPTH));
    launch_s     = src_valid && src_ready;
  end

  // In-flight counter next value; an arrival with nothing recorded in flight is not counted down
  always_comb begin
    inflight_next_s = inflight_r;
    case ({launch_s, pipe_out_valid})
      2'b10: inflight_next_s = inflight_r + CW'(1'b1);
      2'b01: begin
        if (inflight_r != {CW{1'b0}}) begin
          inflight_next_s = inflight_r - CW'(1'b1);
        end else begin
          inflight_next_s = inflight_r;
        end
      end
      default: inflight_next_s = inflight_r;
    endcase
  end

  // In-flight counter and serializer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= {CW{1'b0}};
      beat_r     <= BEAT_LO;
    end else begin
      inflight_r <= inflight_next_s;
      beat_r     <= beat_next_s;
    end
  end

  // Serializer: outputs derive from registers only, data forced to zero while idle
  always_comb begin
    beat_next_s = beat_r;
    m_valid_s   = 1'b0;
    m_data_s    = {OW{1'b0}};
    m_last_s    = 1'b0;
    pop_s       = 1'b0;
    case (beat_r)
      BEAT_LO: begin
        if (count_s != {CW{1'b0}}) begin
          m_valid_s = 1'b1;
          m_data_s  = head_s[OW-1:0];
          if (m_ready) begin
            beat_next_s = BEAT_HI;
          end else begin
            beat_next_s = BEAT_LO;
          end
        end else begin
          beat_next_s = BEAT_LO;
        end
      end
      BEAT_HI: begin
        m_valid_s = 1'b1;
        m_data_s  = head_s[DW-1:OW];
        m_last_s  = 1'b1;
        if (m_ready) begin
          pop_s       = 1'b1;
          beat_next_s = BEAT_LO;
        end else begin
          beat_next_s = BEAT_HI;
        end
      end
      default: beat_next_s = BEAT_LO;
    endcase
  end

  assign m_valid  = m_valid_s;
  assign m_data   = m_data_s;
  assign m_last   = m_last_s;
  assign level    = count_s;
  assign overflow = overflow_s;

endmodule
